// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU: opcode encoding, opcode width
// and result-register FSM state encoding.
package alu_pkg;

  localparam int unsigned ALU_OPW = 3;

  typedef enum logic [ALU_OPW-1:0] {
    OpAnd   = 3'd0,
    OpOr    = 3'd1,
    OpXor   = 3'd2,
    OpNor   = 3'd3,
    OpAdd   = 3'd4,
    OpSub   = 3'd5,
    OpSlt   = 3'd6,
    OpPassA = 3'd7
  } alu_op_e;

  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath shared by both requesters.
// Optional feature macro: ALU_ARB_OVF_EN adds the signed-overflow output.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = ALU_OPW
) (
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef ALU_ARB_OVF_EN
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] result
);

  logic [ALU_OPW-1:0] op_sel;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic               slt;

  assign op_sel = op[ALU_OPW-1:0];
  assign sum    = a + b;
  assign diff   = a - b;
  assign slt    = $signed(a) < $signed(b);

  // Opcode decode to the result value.
  always_comb begin
    result = '0;
    unique case (alu_op_e'(op_sel))
      OpAnd:   result = a & b;
      OpOr:    result = a | b;
      OpXor:   result = a ^ b;
      OpNor:   result = ~(a | b);
      OpAdd:   result = sum;
      OpSub:   result = diff;
      OpSlt:   result = {{(WIDTH-1){1'b0}}, slt};
      OpPassA: result = a;
      default: result = a;
    endcase
  end

`ifdef ALU_ARB_OVF_EN
  // Signed overflow: operand signs imply a result sign that did not occur.
  always_comb begin
    ovf = 1'b0;
    unique case (alu_op_e'(op_sel))
      OpAdd:   ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      OpSub:   ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      default: ovf = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/alu_arb.sv
// Two-requester round-robin arbiter in front of one shared ALU, with a
// one-entry result register (1-cycle issue latency, 1 op/cycle throughput).
// Optional feature macro: ALU_ARB_OVF_EN adds the registered res_ovf output.
module alu_arb
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = ALU_OPW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
`ifdef ALU_ARB_OVF_EN
  output logic             res_ovf,
`endif
  output logic             res_zero
);

  arb_state_e       state_q, state_d;
  logic             ptr_q;
  logic [WIDTH-1:0] data_q;
  logic             id_q;
  logic             zero_q;
  logic             grant_ok;
  logic             grant0;
  logic             grant1;
  logic             grant;
  logic [OPW-1:0]   sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] alu_result;
`ifdef ALU_ARB_OVF_EN
  logic             alu_ovf;
  logic             ovf_q;
`endif

  // Grant decision: slot free now (empty, or held result consumed this cycle).
  // rst_n gating keeps both readys low while reset is held.
  always_comb begin
    grant_ok = rst_n && ((state_q == StEmpty) || res_ready);
    grant0   = grant_ok && req0_valid && (!req1_valid || !ptr_q);
    grant1   = grant_ok && req1_valid && (!req0_valid || ptr_q);
    grant    = grant0 || grant1;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Operand mux feeding the single shared ALU.
  always_comb begin
    sel_op = grant1 ? req1_op : req0_op;
    sel_a  = grant1 ? req1_a  : req0_a;
    sel_b  = grant1 ? req1_b  : req0_b;
  end

  alu_core #(
    .WIDTH (WIDTH),
    .OPW   (OPW)
  ) u_alu_core (
    .op     (sel_op),
    .a      (sel_a),
    .b      (sel_b),
`ifdef ALU_ARB_OVF_EN
    .ovf    (alu_ovf),
`endif
    .result (alu_result)
  );

  // Next-state logic for the result register occupancy.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (grant) state_d = StFull;
      StFull:  if (grant) state_d = StFull;
               else if (res_ready) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  // State register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant0) ptr_q <= 1'b1;
      else if (grant1) ptr_q <= 1'b0;
    end
  end

  // Result register: loads only on grant, so it holds under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      id_q   <= 1'b0;
      zero_q <= 1'b0;
`ifdef ALU_ARB_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else if (grant) begin
      data_q <= alu_result;
      id_q   <= grant1;
      zero_q <= (alu_result == '0);
`ifdef ALU_ARB_OVF_EN
      ovf_q  <= alu_ovf;
`endif
    end
  end

  assign res_valid = (state_q == StFull);
  assign res_data  = data_q;
  assign res_id    = id_q;
  assign res_zero  = zero_q;
`ifdef ALU_ARB_OVF_EN
  assign res_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_alu_arb.sv
// Directed self-checking bench for alu_arb (WIDTH=32, OPW=3).
// Define ALU_ARB_OVF_EN to also exercise res_ovf.
module tb_alu_arb;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic        res_id, res_zero;
`ifdef ALU_ARB_OVF_EN
  logic        res_ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  alu_arb #(
    .WIDTH (32),
    .OPW   (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_id     (res_id),
`ifdef ALU_ARB_OVF_EN
    .res_ovf    (res_ovf),
`endif
    .res_zero   (res_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Issue one op from requester 0 alone with res_ready high; called at a negedge.
  task automatic issue0(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input logic exp_ovf);
    req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    req1_valid = 1'b0; res_ready = 1'b1;
    #1;
    check({tag, "_rdy0"}, 64'(req0_ready), 64'd1);
    @(posedge clk); #1;
    check({tag, "_valid"}, 64'(res_valid), 64'd1);
    check({tag, "_data"}, 64'(res_data), 64'(exp));
    check({tag, "_id"}, 64'(res_id), 64'd0);
    check({tag, "_zero"}, 64'(res_zero), 64'(exp == 32'd0));
`ifdef ALU_ARB_OVF_EN
    check({tag, "_ovf"}, 64'(res_ovf), 64'(exp_ovf));
`endif
    @(negedge clk);
  endtask

  initial begin
    // Reset held with both requesters valid.
    rst_n = 1'b0; res_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b1; req1_op = 3'd0; req1_a = '0; req1_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(res_valid), 64'd0);
    check("rst_rdy0", 64'(req0_ready), 64'd0);
    check("rst_rdy1", 64'(req1_ready), 64'd0);
    check("rst_data", 64'(res_data), 64'd0);
    check("rst_id", 64'(res_id), 64'd0);
    check("rst_zero", 64'(res_zero), 64'd0);

    // Contention: req0 XOR, req1 ADD, steady res_ready; grants alternate from req0.
    @(negedge clk);
    rst_n = 1'b1; res_ready = 1'b1;
    req0_op = 3'd2; req0_a = 32'hFFFF0000; req0_b = 32'h0F0F0F0F;
    req1_op = 3'd4; req1_a = 32'd1;        req1_b = 32'd2;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("cont_rdy0", 64'(req0_ready), 64'((i % 2) == 0));
      check("cont_rdy1", 64'(req1_ready), 64'((i % 2) == 1));
      @(posedge clk); #1;
      check("cont_valid", 64'(res_valid), 64'd1);
      check("cont_data", 64'(res_data), ((i % 2) == 0) ? 64'hF0F00F0F : 64'd3);
      check("cont_id", 64'(res_id), 64'((i % 2) == 1));
      @(negedge clk);
    end

    // Backpressure: req1 SUB 5-5 granted, then result held while res_ready low.
    req0_valid = 1'b0;
    req1_op = 3'd5; req1_a = 32'd5; req1_b = 32'd5;
    #1;
    check("bp_rdy1", 64'(req1_ready), 64'd1);
    @(posedge clk); #1;
    check("bp_data", 64'(res_data), 64'd0);
    check("bp_zero", 64'(res_zero), 64'd1);
    @(negedge clk);
    res_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 32'hFFFFFFFF; req0_b = 32'h1234;
    req1_op = 3'd1; req1_a = 32'h55; req1_b = 32'hAA;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_hold_rdy0", 64'(req0_ready), 64'd0);
      check("bp_hold_rdy1", 64'(req1_ready), 64'd0);
      @(posedge clk); #1;
      check("bp_hold_valid", 64'(res_valid), 64'd1);
      check("bp_hold_data", 64'(res_data), 64'd0);
      check("bp_hold_id", 64'(res_id), 64'd1);
      check("bp_hold_zero", 64'(res_zero), 64'd1);
      @(negedge clk);
    end

    // Back-to-back: FULL + res_ready, SLT -1 < 1 signed -> 1; then 1 < -1 -> 0.
    issue0("b2b_slt_neg", 3'd6, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0);
    issue0("b2b_slt_pos", 3'd6, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0);

    // Consume without grant empties the register.
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
    @(posedge clk); #1;
    check("drain_valid", 64'(res_valid), 64'd0);
    check("drain_data_kept", 64'(res_data), 64'd0);
    @(negedge clk);

    // Remaining opcodes and wrap-around.
    issue0("op_and", 3'd0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0);
    issue0("op_or",  3'd1, 32'hF000_0001, 32'h0000_0F10, 32'hF000_0F11, 1'b0);
    issue0("op_nor", 3'd3, 32'hFFFF_0000, 32'h00FF_00F0, 32'h0000_FF0F, 1'b0);
    issue0("op_pass", 3'd7, 32'hDEAD_BEEF, 32'h1111_1111, 32'hDEAD_BEEF, 1'b0);
    issue0("add_wrap", 3'd4, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0);
    issue0("sub_wrap", 3'd5, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0);
    issue0("sub_ovf", 3'd5, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b1);
    issue0("add_ovf", 3'd4, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b1);
    issue0("and_noovf", 3'd0, 32'h7FFF_FFFF, 32'd1, 32'd1, 1'b0);

    // Mid-reset while FULL: res_valid falls without a clock edge.
    req0_valid = 1'b0; res_ready = 1'b0;
    @(posedge clk); #1;
    check("mr_full", 64'(res_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_valid", 64'(res_valid), 64'd0);
    check("mr_data", 64'(res_data), 64'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("mr_rdy0", 64'(req0_ready), 64'd0);
    check("mr_rdy1", 64'(req1_ready), 64'd0);

    // Pointer was left favouring req1; after reset req0 must win again.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_rdy0", 64'(req0_ready), 64'd1);
    check("post_rst_rdy1", 64'(req1_ready), 64'd0);
    @(posedge clk); #1;
    check("post_rst_valid", 64'(res_valid), 64'd1);
    check("post_rst_id", 64'(res_id), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
